// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
//   Shared types and default constants for the input conditioning path
//   (sync_chain + sync_debounce).
//
//   Contents:
//     deb_state_t          debounce FSM state encoding (STABLE, CHECK)
//     DEB_SYNC_STAGES_DEF  default synchroniser depth
//     DEB_CYCLES_DEF       default number of cycles a new level must hold
//     DEB_SYNC_STAGES_MIN/MAX, DEB_CYCLES_MIN/MAX  legal parameter ranges
//     deb_cnt_w_ok()       checks that a counter width can hold DEB_CYCLES-1
// -----------------------------------------------------------------------------
package debounce_pkg;

    typedef enum logic {
        STABLE = 1'b0,
        CHECK  = 1'b1
    } deb_state_t;

    localparam int DEB_SYNC_STAGES_DEF = 2;
    localparam int DEB_CYCLES_DEF      = 4;

    localparam int DEB_SYNC_STAGES_MIN = 2;
    localparam int DEB_SYNC_STAGES_MAX = 4;
    localparam int DEB_CYCLES_MIN      = 2;
    localparam int DEB_CYCLES_MAX      = 255;

    // True when a cnt_w-bit counter can represent every value up to deb_cycles.
    function automatic bit deb_cnt_w_ok(input int cnt_w, input int deb_cycles);
        return (cnt_w > 0) && (cnt_w < 31) && ((1 << cnt_w) > deb_cycles);
    endfunction

endpackage : debounce_pkg

// File: rtl/sync_chain.sv
// -----------------------------------------------------------------------------
// sync_chain
//   Plain flop-chain synchroniser for a single asynchronous level. Used by
//   sync_debounce and by any other clock-crossing control input.
//
//   Parameters:
//     SYNC_STAGES  number of flops in the chain (2..4)
//     RST_VAL      value every flop takes while rst_n is low
//
//   Ports:
//     clk    input   system clock, all flops on posedge
//     rst_n  input   asynchronous active-low reset
//     d      input   asynchronous level
//     q      output  synchronised level (last flop of the chain)
// -----------------------------------------------------------------------------
module sync_chain
    import debounce_pkg::*;
#(
    parameter int   SYNC_STAGES = DEB_SYNC_STAGES_DEF,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    generate
        if ((SYNC_STAGES < DEB_SYNC_STAGES_MIN) || (SYNC_STAGES > DEB_SYNC_STAGES_MAX)) begin : g_bad_stages
            $error("sync_chain: SYNC_STAGES must be in 2..4");
        end
    endgenerate

    // Bit 0 samples the pin; nothing sits between stages so each flop gets a
    // full cycle to resolve metastability.
    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule : sync_chain

// File: rtl/sync_debounce.sv
// -----------------------------------------------------------------------------
// sync_debounce
//   Conditions a raw, possibly bouncy asynchronous level (button, external pin)
//   into a clean level for edge_det. The input is first synchronised by
//   sync_chain, then a new level is accepted only after it has been seen on
//   DEB_CYCLES consecutive cycles.
//
//   Optional feature macro: SYNC_DEBOUNCE_GLITCH_CNT_EN
//     defined   -> glitch_cnt port and a saturating rejected-transition counter
//     undefined -> port and counter absent, all other behaviour identical
//
//   Parameters:
//     SYNC_STAGES  synchroniser depth (2..4)
//     DEB_CYCLES   consecutive cycles a new level must hold (2..255)
//     RST_VAL      reset value of the sync chain and of data_out
//     CNT_W        width of stability / glitch counters, 2^CNT_W > DEB_CYCLES
//
//   Ports:
//     clk         input   system clock
//     rst_n       input   asynchronous active-low reset
//     din_async   input   raw asynchronous level
//     data_out    output  debounced synchronised level (feeds edge_det.data)
//     busy        output  high while a candidate change is being qualified
//     glitch_cnt  output  rejected-transition count (macro builds only)
//
//   FSM states:
//     state  | meaning
//     -------+---------------------------------------------------------------
//     STABLE | synchronised input equals data_out, nothing pending
//     CHECK  | synchronised input differs, counting consecutive cycles
// -----------------------------------------------------------------------------
module sync_debounce
    import debounce_pkg::*;
#(
    parameter int   SYNC_STAGES = DEB_SYNC_STAGES_DEF,
    parameter int   DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter logic RST_VAL     = 1'b0,
    parameter int   CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din_async,
    output logic             data_out,
    output logic             busy
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [CNT_W-1:0] glitch_cnt
`endif
);

    generate
        if ((DEB_CYCLES < DEB_CYCLES_MIN) || (DEB_CYCLES > DEB_CYCLES_MAX)) begin : g_bad_deb
            $error("sync_debounce: DEB_CYCLES must be in 2..255");
        end
        if (!deb_cnt_w_ok(CNT_W, DEB_CYCLES)) begin : g_bad_cnt_w
            $error("sync_debounce: CNT_W too narrow, need 2^CNT_W > DEB_CYCLES");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync_q;

    deb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             data_q,  data_d;
    logic             busy_q,  busy_d;

    sync_chain #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (RST_VAL)
    ) u_sync_chain (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (din_async),
        .q     (sync_q)
    );

    // cnt_q counts how many consecutive cycles the differing level has been
    // seen; entering CHECK already counts the first one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;

        case (state_q)
            STABLE: begin
                if (sync_q != data_q) begin
                    state_d = CHECK;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end

            CHECK: begin
                if (sync_q == data_q) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    data_d  = sync_q;
                    state_d = STABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = STABLE;
                cnt_d   = '0;
            end
        endcase

        // busy is a flop that tracks the state register exactly.
        busy_d = (state_d == CHECK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STABLE;
            cnt_q   <= '0;
            data_q  <= RST_VAL;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
        end
    end

    assign data_out = data_q;
    assign busy     = busy_q;

`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    // A glitch is a CHECK that falls back to STABLE because the input
    // reverted before qualifying.
    logic             glitch_evt;
    logic [CNT_W-1:0] glitch_q, glitch_d;

    assign glitch_evt = (state_q == CHECK) && (sync_q == data_q);

    always_comb begin
        glitch_d = glitch_q;
        if (glitch_evt && (glitch_q != {CNT_W{1'b1}})) begin
            glitch_d = glitch_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_q <= '0;
        end else begin
            glitch_q <= glitch_d;
        end
    end

    assign glitch_cnt = glitch_q;
`endif

endmodule : sync_debounce
